// File: rtl/mem_port_arb.sv
// Shares one single-port memory between instruction fetch and load/store.
// One access is outstanding at a time, data normally has priority, and a starvation limit bounds fetch delay.
module mem_port_arb #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_LIM = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_done,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_done,
   output logic [DW-1:0] d_rdata,
   output logic          stall_if,
   output logic          stall_mem,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_rdata
);

   // state  | meaning
   // IDLE   | no access outstanding, arbitrate every cycle
   // BUSY_I | fetch access on the memory, waiting for mem_ack
   // BUSY_D | load/store access on the memory, waiting for mem_ack
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   localparam logic [3:0] LIM = 4'(STARVE_LIM);

   state_t        state_q, state_d;
   logic          mem_en_q, mem_en_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]    starve_cnt_q, starve_cnt_d;

   logic arb_en;
   logic if_cand;
   logic d_cand;
   logic force_i;
   logic grant_i;
   logic grant_d;

   // Done is suppressed when the owner has dropped its request (flush).
   assign if_done   = (state_q == BUSY_I) && mem_ack && if_req;
   assign d_done    = (state_q == BUSY_D) && mem_ack && d_req;
   assign if_rdata  = if_done ? mem_rdata : '0;
   assign d_rdata   = d_done ? mem_rdata : '0;
   assign stall_if  = if_req && !if_done;
   assign stall_mem = d_req && !d_done;

   assign arb_en = (state_q == IDLE) || mem_ack;

   // A finished store/load must never be replayed, so data is always excluded in its done cycle.
   // A fetch still requesting in its done cycle is the next fetch and may stream unless data waits.
   assign d_cand  = d_req && !d_done;
   assign if_cand = if_req && !(if_done && d_cand);
   assign force_i = (starve_cnt_q == LIM) && if_cand;
   assign grant_d = d_cand && !force_i;
   assign grant_i = if_cand && !grant_d;

   always_comb begin
      state_d      = state_q;
      mem_en_d     = mem_en_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      starve_cnt_d = starve_cnt_q;
      if (arb_en) begin
         if (grant_d) begin
            state_d     = BUSY_D;
            mem_en_d    = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
         end else if (grant_i) begin
            state_d     = BUSY_I;
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
         end else begin
            state_d  = IDLE;
            mem_en_d = 1'b0;
            mem_we_d = 1'b0;
         end
         if (grant_i) begin
            starve_cnt_d = 4'd0;
         end else if (grant_d && if_req && (starve_cnt_q != LIM)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         starve_cnt_q <= 4'd0;
      end else begin
         state_q      <= state_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb with a wait-state memory model.
// Read data returned by the model is mem_addr ^ 32'h5A5A_0000.
module tb_mem_port_arb;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_done;
   logic [31:0] d_rdata;
   logic        stall_if;
   logic        stall_mem;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   logic [3:0]  waits;
   logic [3:0]  wcnt;
   logic        ack_force;
   int          n_cmp;
   int          n_err;

   mem_port_arb #(.AW(32), .DW(32), .STARVE_LIM(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                wcnt <= 4'd0;
      else if (!mem_en || mem_ack) wcnt <= 4'd0;
      else                       wcnt <= wcnt + 4'd1;
   end

   assign mem_ack   = (mem_en && (wcnt == waits)) || ack_force;
   assign mem_rdata = mem_ack ? (mem_addr ^ 32'h5A5A_0000) : 32'h0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int   n;
      logic seen;
      n    = 0;
      seen = 1'b0;
      #2;
      while (mem_en && n < 20) begin
         seen = seen | if_done | d_done;
         cyc();
         #2;
         n++;
      end
      chk({tag, "_idle"}, 32'(mem_en), 32'd0);
      chk({tag, "_no_done"}, 32'(seen), 32'd0);
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
      d_addr = '0; d_wdata = '0; waits = 4'd0; ack_force = 1'b0;
      #2;
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_if_done", 32'(if_done), 32'd0);
      chk("rst_d_done", 32'(d_done), 32'd0);
      chk("rst_stall_if", 32'(stall_if), 32'd0);
      chk("rst_stall_mem", 32'(stall_mem), 32'd0);
      chk("rst_starve", 32'(dut.starve_cnt_q), 32'd0);
      cyc(); rst_n = 1'b1;

      // fetch only, zero-wait memory
      cyc(); if_req = 1'b1; if_addr = 32'h100; #2;
      chk("f_c0_mem_en", 32'(mem_en), 32'd0);
      chk("f_c0_stall_if", 32'(stall_if), 32'd1);
      chk("f_c0_if_done", 32'(if_done), 32'd0);
      cyc(); #2;
      chk("f_c1_mem_en", 32'(mem_en), 32'd1);
      chk("f_c1_mem_addr", mem_addr, 32'h100);
      chk("f_c1_if_done", 32'(if_done), 32'd1);
      chk("f_c1_if_rdata", if_rdata, 32'h5A5A_0100);
      chk("f_c1_stall_if", 32'(stall_if), 32'd0);
      cyc(); if_addr = 32'h104; #2;
      chk("f_c2_if_done", 32'(if_done), 32'd1);
      chk("f_c2_mem_addr", mem_addr, 32'h100);
      cyc(); #2;
      chk("f_c3_mem_addr", mem_addr, 32'h104);
      chk("f_c3_if_rdata", if_rdata, 32'h5A5A_0104);
      cyc(); if_req = 1'b0; #2;
      chk("f_c4_mem_en", 32'(mem_en), 32'd1);
      chk("f_c4_if_done", 32'(if_done), 32'd0);
      chk("f_c4_if_rdata", if_rdata, 32'd0);
      cyc(); #2;
      chk("f_c5_mem_en", 32'(mem_en), 32'd0);

      // simultaneous requests, two wait states
      waits = 4'd2;
      cyc(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; if_req = 1'b1; if_addr = 32'h104; #2;
      chk("s_c0_mem_en", 32'(mem_en), 32'd0);
      chk("s_c0_stall_if", 32'(stall_if), 32'd1);
      chk("s_c0_stall_mem", 32'(stall_mem), 32'd1);
      cyc(); #2;
      chk("s_c1_mem_addr", mem_addr, 32'h2000);
      chk("s_c1_mem_we", 32'(mem_we), 32'd0);
      chk("s_c1_d_done", 32'(d_done), 32'd0);
      cyc(); #2;
      chk("s_c2_d_done", 32'(d_done), 32'd0);
      chk("s_c2_stall_mem", 32'(stall_mem), 32'd1);
      cyc(); #2;
      chk("s_c3_d_done", 32'(d_done), 32'd1);
      chk("s_c3_d_rdata", d_rdata, 32'h5A5A_2000);
      chk("s_c3_stall_if", 32'(stall_if), 32'd1);
      chk("s_c3_stall_mem", 32'(stall_mem), 32'd0);
      cyc(); d_req = 1'b0; #2;
      chk("s_c4_mem_addr", mem_addr, 32'h104);
      chk("s_c4_d_done", 32'(d_done), 32'd0);
      cyc(); #2;
      chk("s_c5_stall_if", 32'(stall_if), 32'd1);
      chk("s_c5_if_done", 32'(if_done), 32'd0);
      cyc(); #2;
      chk("s_c6_if_done", 32'(if_done), 32'd1);
      chk("s_c6_if_rdata", if_rdata, 32'h5A5A_0104);
      chk("s_c6_stall_if", 32'(stall_if), 32'd0);
      chk("s_c6_d_rdata", d_rdata, 32'd0);
      cyc(); if_req = 1'b0;
      wait_idle("s_end");

      // flush abandon, three wait states, data pending
      cyc(); if_req = 1'b1; if_addr = 32'h200; waits = 4'd3; #2;
      chk("a_c0_mem_en", 32'(mem_en), 32'd0);
      cyc(); #2;
      chk("a_c1_mem_addr", mem_addr, 32'h200);
      cyc(); if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; #2;
      chk("a_c2_if_done", 32'(if_done), 32'd0);
      chk("a_c2_stall_mem", 32'(stall_mem), 32'd1);
      cyc(); #2;
      chk("a_c3_if_done", 32'(if_done), 32'd0);
      cyc(); #2;
      chk("a_c4_mem_en", 32'(mem_en), 32'd1);
      chk("a_c4_mem_addr", mem_addr, 32'h200);
      chk("a_c4_if_done", 32'(if_done), 32'd0);
      chk("a_c4_if_rdata", if_rdata, 32'd0);
      chk("a_c4_d_done", 32'(d_done), 32'd0);
      cyc(); waits = 4'd0; #2;
      chk("a_c5_mem_addr", mem_addr, 32'h300);
      chk("a_c5_d_done", 32'(d_done), 32'd1);
      chk("a_c5_d_rdata", d_rdata, 32'h5A5A_0300);
      cyc(); d_req = 1'b0; #2;
      chk("a_c6_mem_en", 32'(mem_en), 32'd0);

      // store with one wait state
      cyc(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; waits = 4'd1; #2;
      chk("w_c0_mem_we", 32'(mem_we), 32'd0);
      cyc(); #2;
      chk("w_c1_mem_we", 32'(mem_we), 32'd1);
      chk("w_c1_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("w_c1_mem_addr", mem_addr, 32'h40);
      chk("w_c1_d_done", 32'(d_done), 32'd0);
      cyc(); #2;
      chk("w_c2_d_done", 32'(d_done), 32'd1);
      chk("w_c2_mem_we", 32'(mem_we), 32'd1);
      cyc(); d_req = 1'b0; d_we = 1'b0; d_wdata = 32'd0; #2;
      chk("w_c3_mem_en", 32'(mem_en), 32'd0);
      chk("w_c3_mem_we", 32'(mem_we), 32'd0);
      chk("w_c3_d_done", 32'(d_done), 32'd0);

      // starvation: four data grants while fetch waits, then fetch is forced
      waits = 4'd0;
      for (int k = 0; k < 4; k++) begin
         cyc(); d_req = 1'b1; d_addr = 32'h1000 + 32'(4 * k); if_req = 1'b1; if_addr = 32'h500; #2;
         chk("v_a_mem_en", 32'(mem_en), 32'd0);
         chk("v_a_starve", 32'(dut.starve_cnt_q), 32'(k));
         cyc(); if_req = 1'b0; #2;
         chk("v_b_mem_addr", mem_addr, 32'h1000 + 32'(4 * k));
         chk("v_b_d_done", 32'(d_done), 32'd1);
         chk("v_b_if_done", 32'(if_done), 32'd0);
      end
      cyc(); d_addr = 32'h1010; if_req = 1'b1; #2;
      chk("v_a5_starve", 32'(dut.starve_cnt_q), 32'd4);
      cyc(); #2;
      chk("v_b5_mem_addr", mem_addr, 32'h500);
      chk("v_b5_if_done", 32'(if_done), 32'd1);
      chk("v_b5_stall_mem", 32'(stall_mem), 32'd1);
      chk("v_b5_starve", 32'(dut.starve_cnt_q), 32'd0);
      cyc(); d_req = 1'b0; if_req = 1'b0; #2;
      chk("v_c5_mem_addr", mem_addr, 32'h1010);
      chk("v_c5_mem_we", 32'(mem_we), 32'd0);
      chk("v_c5_d_done", 32'(d_done), 32'd0);
      chk("v_c5_starve", 32'(dut.starve_cnt_q), 32'd1);
      cyc();
      wait_idle("v_end");

      // reset in the middle of a data access
      cyc(); d_req = 1'b1; d_addr = 32'h80; waits = 4'd5; #2;
      cyc(); #2;
      chk("r_c1_mem_en", 32'(mem_en), 32'd1);
      cyc(); #2;
      chk("r_c2_d_done", 32'(d_done), 32'd0);
      rst_n = 1'b0; #1;
      chk("r_rst_mem_en", 32'(mem_en), 32'd0);
      chk("r_rst_d_done", 32'(d_done), 32'd0);
      chk("r_rst_mem_addr", mem_addr, 32'd0);
      d_req = 1'b0; #1;
      chk("r_rst_stall_mem", 32'(stall_mem), 32'd0);
      chk("r_rst_starve", 32'(dut.starve_cnt_q), 32'd0);
      cyc(); cyc(); rst_n = 1'b1;

      // stray mem_ack in IDLE is ignored; fetch proceeds afterwards
      cyc(); if_req = 1'b1; if_addr = 32'h600; ack_force = 1'b1; #2;
      chk("i_c0_if_done", 32'(if_done), 32'd0);
      chk("i_c0_if_rdata", if_rdata, 32'd0);
      chk("i_c0_stall_if", 32'(stall_if), 32'd1);
      chk("i_c0_mem_en", 32'(mem_en), 32'd0);
      cyc(); #2;
      chk("i_c1_if_done", 32'(if_done), 32'd1);
      chk("i_c1_mem_addr", mem_addr, 32'h600);
      chk("i_c1_if_rdata", if_rdata, 32'h5A5A_0600);
      cyc(); if_req = 1'b0; ack_force = 1'b0;
      wait_idle("i_end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Arbiter that shares one single-port instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage core. It keeps at most one memory transaction outstanding and routes the completion and read data back to the requester that owns it. It also produces the fetch/data stall terms that freeze the IF→ID register and hold the pipeline while a stage waits. Data accesses have priority, and a starvation counter bounds how long fetch can be held off.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_LIM, 4, consecutive data grants made while fetch waits before fetch is forced to win once (1..15)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held until if_done or until dropped by flush
- if_addr  in  AW  fetch address; stable while if_req is high
- if_done  out  1  fetch complete; if_rdata valid this cycle
- if_rdata  out  DW  instruction word
- d_req  in  1  data request; held until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_done  out  1  data access complete; d_rdata valid for loads
- d_rdata  out  DW  load data
- stall_if  out  1  if_req & ~if_done
- stall_mem  out  1  d_req & ~d_done
- mem_en  out  1  memory access active
- mem_we  out  1  write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_ack  in  1  memory completes the current access (may be asserted in the first mem_en cycle)
- mem_rdata  in  DW  memory read data, valid with mem_ack

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- **IDLE.** Arbitrate on the current cycle's requests and register the winner.
  - Winner is data if d_req, except when starve_cnt == STARVE_LIM and if_req; then fetch wins.
  - Fetch wins if only if_req is high.
  - With no request, stay in IDLE.
- **Grant.** On the grant edge, latch the winner's addr/we/wdata into the mem_* registers and go to BUSY_I or BUSY_D.
- **BUSY_x.**
  - mem_en = 1 and the mem_* outputs hold until mem_ack.
  - On the mem_ack cycle, done for the owner = mem_ack (combinational), and rdata passes through from mem_rdata.
  - At the ack edge, arbitrate again exactly as in IDLE on current requests, excluding a requester whose done is high this cycle.
  - The result is back-to-back BUSY, or IDLE.
- **Abandoned transaction.** If the owner drops req while BUSY_x (pipeline flush), the memory access still completes. The owner's done is suppressed, and rdata is discarded.
- **Starvation counter** (starve_cnt, 4 bits):
  - increments on each data grant made while if_req is high, saturating at STARVE_LIM;
  - clears on every fetch grant;
  - holds otherwise.
- **Stores vs. loads.** For stores, d_done still pulses on ack; d_rdata is don't-care.
- **Idle outputs.** if_rdata and d_rdata are 0 when the corresponding done is low.

## Timing
- **Reset values.** Async reset → IDLE. mem_en = mem_we = 0, mem_addr = mem_wdata = 0, starve_cnt = 0. if_done = d_done = 0 and stall_if = stall_mem = 0, given the request inputs are low.
- **Reset mid-transaction.** Abort immediately. mem_en drops asynchronously and no done is produced.
- **Minimum latency.** req in cycle 0 (IDLE) → mem_en in cycle 1 → with zero-wait memory, mem_ack and done in cycle 1.
  - Fetch throughput: one access per cycle when back-to-back.
- **Wait states.** Each cycle of mem_ack = 0 extends BUSY by one cycle, with stall_* held high.
- **Simultaneous requests in IDLE.** Data is served first; fetch is served at the ack edge, with no idle bubble.
- **Registered vs. combinational outputs.** mem_en, mem_we, mem_addr and mem_wdata are registered. if_done, d_done, rdata and stall_* are combinational.
- **Ignored input.** mem_ack outside BUSY is ignored.

## Test plan
- **Fetch only, zero-wait memory.** if_req=1, if_addr=0x100, mem_ack tied to mem_en. Expect mem_en high from cycle 1, mem_addr=0x100, if_done every cycle from cycle 1, stall_if=1 only in cycle 0.
- **Simultaneous requests.** In IDLE, d_req load at 0x2000 and if_req at 0x104, memory with 2 wait states. Expect data served first (d_done in cycle 3), then fetch granted at that edge (if_done in cycle 6), stall_if high for cycles 0–5.
- **Starvation.** STARVE_LIM=4, d_req held high with a new address each done, if_req held high. Expect 4 data grants, then a fetch grant, then starve_cnt=0.
- **Flush abandon.** Fetch in BUSY_I with 3 wait states; drop if_req in the 2nd cycle. Expect the access to complete with no if_done; a pending d_req is granted on the ack edge.
- **Store.** d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF. Expect mem_we=1 and mem_wdata=0xDEADBEEF until ack, d_done pulses once, and mem_we returns to 0.
- **Reset mid-operation.** Assert rst_n=0 in BUSY_D before ack. Expect mem_en=0 immediately, no d_done, and after release the FSM in IDLE with starve_cnt=0.
